// File: rtl/multiplier_sat_sweeper.sv
// multiplier_sat_sweeper
// Brute-force stimulus source for a combinational multiplier_*_sat benchmark.
// Walks idx = {a_out, b_out} from 0 to 2^N-1, samples the benchmark's sat
// output and presents every satisfying assignment on a valid/ready port.
// Optional build macro: SWEEP_STOP_FIRST_EN -- when defined, the sweep ends
// at the first accepted solution instead of reporting all of them.
module multiplier_sat_sweeper #(
  parameter int unsigned A_WIDTH = 4,
  parameter int unsigned B_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [A_WIDTH-1:0]         a_out,
  output logic [B_WIDTH-1:0]         b_out,
  input  logic                       sat_in,
  output logic                       sol_valid,
  input  logic                       sol_ready,
  output logic [A_WIDTH-1:0]         sol_a,
  output logic [B_WIDTH-1:0]         sol_b,
  output logic [A_WIDTH+B_WIDTH:0]   sol_count,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned N = A_WIDTH + B_WIDTH;
  localparam logic [N-1:0] IDX_MAX = '1;

`ifdef SWEEP_STOP_FIRST_EN
  localparam bit STOP_FIRST = 1'b1;
`else
  localparam bit STOP_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [A_WIDTH-1:0]   sol_a_q, sol_a_d;
  logic [B_WIDTH-1:0]   sol_b_q, sol_b_d;
  logic [N:0]           cnt_q, cnt_d;

  // State and datapath registers; reset aborts any sweep with no retained result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sol_a_q <= '0;
      sol_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sol_a_q <= sol_a_d;
      sol_b_q <= sol_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: probe one candidate per cycle, park in HOLD on a hit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sol_a_d = sol_a_q;
    sol_b_d = sol_b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = PROBE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      PROBE: begin
        if (sat_in) begin
          // Capture from idx_q, which is exactly what a_out/b_out present.
          sol_a_d = idx_q[N-1:B_WIDTH];
          sol_b_d = idx_q[B_WIDTH-1:0];
          state_d = HOLD;
        end else if (idx_q == IDX_MAX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + N'(1);
        end
      end
      HOLD: begin
        if (sol_ready) begin
          cnt_d = cnt_q + (N+1)'(1);
          if (STOP_FIRST || (idx_q == IDX_MAX)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + N'(1);
            state_d = PROBE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from registers, so the benchmark sees clean
  // operands and the sat path is a single register-to-register cycle.
  assign a_out     = idx_q[N-1:B_WIDTH];
  assign b_out     = idx_q[B_WIDTH-1:0];
  assign sol_a     = sol_a_q;
  assign sol_b     = sol_b_q;
  assign sol_count = cnt_q;
  assign sol_valid = (state_q == HOLD);
  assign busy      = (state_q == PROBE) || (state_q == HOLD);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_multiplier_sat_sweeper.sv
// tb_multiplier_sat_sweeper
// Bench for multiplier_sat_sweeper with default widths; the benchmark circuit
// is modelled as sat = (a*b == 15). Honors SWEEP_STOP_FIRST_EN like the RTL.
module tb_multiplier_sat_sweeper;

  localparam int AW      = 4;
  localparam int BW      = 3;
  localparam int N       = AW + BW;
  localparam int IDX_MAX = (1 << N) - 1;

`ifdef SWEEP_STOP_FIRST_EN
  localparam bit STOP_FIRST = 1'b1;
`else
  localparam bit STOP_FIRST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sol_ready = 1'b1;
  logic          sat_in;
  logic          sol_valid, busy, done;
  logic [AW-1:0] a_out, sol_a;
  logic [BW-1:0] b_out, sol_b;
  logic [N:0]    sol_count;
  logic          sat_zero = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  typedef struct {
    int a;
    int b;
    int cyc;
  } sol_t;
  sol_t exp_q[$];

  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;
  int rise_cyc = 0;
  bit nxt_pend = 1'b0;
  int nxt_idx = 0;
  int mon_idx = 0;
  int model_last_a = 0;
  int model_last_b = 0;

  multiplier_sat_sweeper #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .sat_in    (sat_in),
    .sol_valid (sol_valid),
    .sol_ready (sol_ready),
    .sol_a     (sol_a),
    .sol_b     (sol_b),
    .sol_count (sol_count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  assign sat_in = !sat_zero && ((int'(a_out) * int'(b_out)) == 15);

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycle label relative to the start edge: the first PROBE cycle is 1.
  function automatic int cur_cyc();
    return edge_cnt - start_edge + 1;
  endfunction

  // Independent timing model: one probe per cycle, a hit costs one HOLD
  // cycle plus any stall applied to the first solution.
  task automatic build_expect(input int stall, output int done_cyc);
    int t;
    t = 1;
    exp_q.delete();
    for (int idx = 0; idx <= IDX_MAX; idx++) begin
      int aa;
      int bb;
      aa = idx / (1 << BW);
      bb = idx % (1 << BW);
      if (!sat_zero && (aa * bb == 15)) begin
        exp_q.push_back('{a: aa, b: bb, cyc: t + 1});
        t += 2 + ((exp_q.size() == 1) ? stall : 0);
        if (STOP_FIRST) break;
      end else begin
        t++;
      end
    end
    done_cyc = t;
  endtask

  // Scoreboard monitor: compare every presented solution, its hold stability,
  // its first-valid cycle and the candidate probed right after acceptance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (nxt_pend) begin
        check("next_probe_idx", {a_out, b_out}, nxt_idx);
        nxt_pend = 1'b0;
      end
      if (sol_valid) begin
        if (!prev_valid) begin
          rise_cyc = cur_cyc();
          if (exp_q.size() == 0) check("unexpected_sol", 1, 0);
        end
        if (exp_q.size() != 0) begin
          check("sol_a", sol_a, exp_q[0].a);
          check("sol_b", sol_b, exp_q[0].b);
          check("a_out_hold", a_out, exp_q[0].a);
          check("b_out_hold", b_out, exp_q[0].b);
          if (sol_ready) begin
            check("sol_valid_cycle", rise_cyc, exp_q[0].cyc);
            mon_idx = exp_q[0].a * (1 << BW) + exp_q[0].b;
            if (mon_idx != IDX_MAX && !STOP_FIRST) begin
              nxt_pend = 1'b1;
              nxt_idx  = mon_idx + 1;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = sol_valid;
    end else begin
      prev_valid = 1'b0;
      nxt_pend   = 1'b0;
    end
  end

  // Called at posedge+1; runs one sweep to DONE and checks the end state.
  task automatic run_sweep(input int stall, input bit repulse);
    int done_exp;
    int cnt_exp;
    int done_at;
    int waited;
    build_expect(stall, done_exp);
    cnt_exp = exp_q.size();
    if (cnt_exp > 0) begin
      model_last_a = exp_q[cnt_exp-1].a;
      model_last_b = exp_q[cnt_exp-1].b;
    end
    sol_ready  = (stall == 0);
    start      = 1'b1;
    start_edge = edge_cnt + 1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_count_clear", sol_count, 0);
    check("start_idx", {a_out, b_out}, 0);
    done_at = -1;
    fork
      if (stall > 0) begin : stall_br
        int k;
        k = 0;
        while (!sol_valid && k < 400) begin
          @(posedge clk);
          #1 k++;
        end
        repeat (stall) @(posedge clk);
        #1 sol_ready = 1'b1;
      end
      if (repulse) begin : repulse_br
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      begin : done_br
        waited = 0;
        while (!done && waited < 600) begin
          @(posedge clk);
          #1 waited++;
        end
        done_at = cur_cyc();
      end
    join
    check("done_seen", done, 1);
    check("done_cycle", done_at, done_exp);
    check("sol_count", sol_count, cnt_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_in_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_holds", done, 1);
    check("count_holds", sol_count, cnt_exp);
    check("sol_a_holds", sol_a, model_last_a);
    check("sol_b_holds", sol_b, model_last_b);
    check("valid_low_in_done", sol_valid, 0);
    if (!STOP_FIRST) check("idx_at_max", {a_out, b_out}, IDX_MAX);
    sol_ready = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_out"}, a_out, 0);
    check({tag, "_b_out"}, b_out, 0);
    check({tag, "_sol_valid"}, sol_valid, 0);
    check({tag, "_sol_a"}, sol_a, 0);
    check({tag, "_sol_b"}, sol_b, 0);
    check({tag, "_sol_count"}, sol_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int d;
    int k;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    mon_en = 1'b1;

    // Full sweep with a start re-pulse during PROBE that must be ignored.
    run_sweep(0, 1'b1);

    // Restart from DONE with sat tied low: no solutions, count cleared.
    sat_zero = 1'b1;
    run_sweep(0, 1'b0);
    sat_zero = 1'b0;

    // Back-pressure: ready held low for 5 cycles at the first solution.
    run_sweep(5, 1'b0);

    // Asynchronous reset while a solution is held.
    build_expect(0, d);
    sol_ready  = 1'b0;
    start      = 1'b1;
    start_edge = edge_cnt + 1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (!sol_valid && k < 400) begin
      @(posedge clk);
      #1 k++;
    end
    check("hold_reached", sol_valid, 1);
    check("hold_sol_a", sol_a, 3);
    #2 mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    exp_q.delete();
    model_last_a = 0;
    model_last_b = 0;
    @(posedge clk);
    #1 check_reset_vals("rst_held");
    rst_n = 1'b1;
    sol_ready = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    run_sweep(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multiplier_sat_sweeper.md
# multiplier_sat_sweeper

Exhaustive stimulus stage that sits directly upstream of a combinational `multiplier_*_sat` benchmark circuit. It drives every `{a, b}` input assignment into the benchmark, one per cycle, and samples the benchmark's `sat` output. Each satisfying assignment is reported over a valid/ready handshake. The block gives a brute-force ground truth for the benchmark before the same circuit is handed to the CSAT solver.

## Interface
Parameters:
- `A_WIDTH`, default 4: width of operand `a` driven to the benchmark.
- `B_WIDTH`, default 3: width of operand `b` driven to the benchmark.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle pulse that begins a sweep; ignored while `busy`.
- `a_out` out `A_WIDTH`: candidate `a`, registered, wired to the benchmark's `a[*]`.
- `b_out` out `B_WIDTH`: candidate `b`, registered, wired to the benchmark's `b[*]`.
- `sat_in` in 1: combinational `sat` from the benchmark for the current `a_out`/`b_out`.
- `sol_valid` out 1: a solution is presented.
- `sol_ready` in 1: consumer accepts the solution.
- `sol_a` out `A_WIDTH`: `a` of the presented solution.
- `sol_b` out `B_WIDTH`: `b` of the presented solution.
- `sol_count` out `A_WIDTH+B_WIDTH+1`: number of solutions accepted in this sweep.
- `busy` out 1: a sweep is in progress (state PROBE or HOLD).
- `done` out 1: the sweep has finished; stays high until the next `start` or reset.

## Operation
- Candidate index `idx` is `{a_out, b_out}`, N = `A_WIDTH+B_WIDTH` bits, so `b` occupies the LSBs.
- Sweep order is `idx` = 0, 1, …, 2^N−1, strictly ascending.
- States:
  - IDLE: reset state. `start` → PROBE with `idx`=0 and `sol_count`=0.
  - PROBE: `sat_in` is sampled every cycle.
    - `sat_in`=1 → latch `sol_a`/`sol_b` from `a_out`/`b_out`, go to HOLD. `idx` does not advance.
    - `sat_in`=0 and `idx`≠max → `idx`+1.
    - `sat_in`=0 and `idx`=max → DONE.
  - HOLD: `sol_valid`=1 and `a_out`/`b_out` hold steady. On `sol_valid && sol_ready`:
    - `sol_count` increments.
    - If `idx`=max → DONE.
    - Otherwise `idx`+1 and return to PROBE.
  - DONE: `done`=1, `idx` holds at max. `start` → PROBE with `idx`=0 and `sol_count` cleared.
- `start` in PROBE or HOLD has no effect.
- `sol_a`, `sol_b` and `sol_count` hold their values in DONE until the next `start`.
- `sol_count` cannot overflow: its maximum is 2^N, which fits in N+1 bits.
- `sat_in` is treated as don't-care outside PROBE.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `sol_valid`=0, `sol_a`=0, `sol_b`=0, `sol_count`=0, `busy`=0, `done`=0; state IDLE.
- Reset asserted mid-sweep aborts immediately to these values. No partial result is retained.
- `start` sampled high at edge T → first PROBE cycle is T+1 with `idx`=0.
- With no solutions, candidate n is probed in cycle T+1+n and `done` rises at T+1+2^N.
- A solution found at probe cycle P raises `sol_valid` at P+1.
  - If `sol_ready` is high at P+1, the next candidate is probed at P+2.
  - Each cycle `sol_ready` stays low adds one cycle of stall.
- While `sol_valid` is high, `sol_valid`, `sol_a` and `sol_b` must not change until accepted.
- The combinational path is `a_out`/`b_out` → benchmark → `sat_in` → capture register. It must close within one cycle.
- Solution at `idx`=max with immediate accept: `done` asserts the cycle after acceptance.

## Configuration
- `SWEEP_STOP_FIRST_EN` defined:
  - The first accepted solution ends the sweep: HOLD → DONE regardless of `idx`.
  - `sol_count` is at most 1.
- `SWEEP_STOP_FIRST_EN` undefined (default): every satisfying assignment is reported, in ascending `idx` order.

## Test plan
All scenarios use default widths; the bench models `sat_in` = (a*b == 15).
- Full sweep, `sol_ready` tied 1, `start` at cycle 0:
  - `sol_valid` pulses with (a,b) = (3,5), (5,3), (15,1) at cycles 31, 46, 125.
  - `done` rises at cycle 132 with `sol_count`=3.
- `sat_in` tied 0, `start` at cycle 0 → `done`=1 at cycle 129, `sol_count`=0, `sol_valid` never asserted.
- `sol_ready` held low 5 cycles at the first solution:
  - `sol_valid`, `sol_a`=3, `sol_b`=5, `a_out`=3 and `b_out`=5 stay stable for all 5 cycles.
  - Candidate 30 is probed exactly one cycle after acceptance.
- `rst_n` pulsed low during HOLD → all outputs return to reset values asynchronously. A fresh `start` re-reports (3,5) first.
- `start` re-pulsed during PROBE is ignored; after DONE, `start` clears `sol_count` and restarts at `idx`=0.
- With `SWEEP_STOP_FIRST_EN` defined → only (3,5) is reported; `done`=1 one cycle after acceptance, `sol_count`=1.
